// File: rtl/decomp_pkg.sv
// Shared definitions for the compressed-stream unpacker: code values,
// per-code byte cost and the block-walking state encoding.
package decomp_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_B8   = 2'b01;
    localparam logic [1:0] CODE_B16  = 2'b10;
    localparam logic [1:0] CODE_RAW  = 2'b11;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        PAY = 2'd1,
        PAD = 2'd2
    } state_t;

    function automatic logic [2:0] need_bytes(input logic [1:0] code);
        case (code)
            CODE_B8:  return 3'd1;
            CODE_B16: return 3'd2;
            CODE_RAW: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/decomp_byte_fifo.sv
// Byte shift buffer: 4-byte push at the tail, 0..4-byte pop from the head.
// The head four bytes are always visible so the consumer can decide before popping.
module decomp_byte_fifo #(
    parameter int BUF_BYTES = 8,
    parameter int CW        = $clog2(BUF_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic [2:0]    pop_n,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic [7:0]    b0,
    output logic [7:0]    b1,
    output logic [7:0]    b2,
    output logic [7:0]    b3
);

    logic [8*BUF_BYTES-1:0] mem_reg;
    logic [8*BUF_BYTES-1:0] mem_next;
    logic [8*BUF_BYTES-1:0] shifted;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          post_cnt;

    assign post_cnt   = count_reg - CW'(pop_n);
    assign count_next = post_cnt + (push ? CW'(4) : CW'(0));

    // Pop first, then the pushed word lands right after the surviving bytes.
    always_comb begin
        shifted  = mem_reg >> {pop_n, 3'b000};
        mem_next = shifted;
        if (push) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                if (i >= int'(post_cnt) && i < int'(post_cnt) + 4) begin
                    mem_next[8*i +: 8] = push_data[8*(i - int'(post_cnt)) +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg   <= '0;
            count_reg <= '0;
        end else begin
            mem_reg   <= mem_next;
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign b0    = mem_reg[7:0];
    assign b1    = mem_reg[15:8];
    assign b2    = mem_reg[23:16];
    assign b3    = mem_reg[31:24];

endmodule

// File: rtl/decomp_unpacker.sv
// Walks header codes of each block and emits one right-aligned payload per
// original word; trailing pad bytes of a block are dropped before the next header.
module decomp_unpacker
    import decomp_pkg::*;
#(
    parameter int BLK_WORDS = 16,
    parameter int BUF_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_decomp_in,
    output logic [1:0]  out_bitmap,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        blk_done
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    state_t        state_reg, state_next;
    logic [31:0]   hdr_reg, hdr_next;
    logic [3:0]    idx_reg, idx_next;
    logic [1:0]    bytecnt_reg, bytecnt_next;
    logic [1:0]    pad_reg, pad_next;
    logic          in_ready_reg;
    logic          out_valid_reg, out_valid_next;
    logic [31:0]   out_data_reg, out_data_next;
    logic [1:0]    out_bm_reg, out_bm_next;
    logic          blk_done_reg, blk_done_next;

    logic          push;
    logic [2:0]    pop_n;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic [7:0]    b0, b1, b2, b3;
    logic          can_load;
    logic [1:0]    code;
    logic [2:0]    need;

    assign push = in_valid && in_ready_reg;

    decomp_byte_fifo #(.BUF_BYTES(BUF_BYTES), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (in_data),
        .pop_n      (pop_n),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .b0         (b0),
        .b1         (b1),
        .b2         (b2),
        .b3         (b3)
    );

    assign can_load = !out_valid_reg || out_ready;
    assign code     = hdr_reg[{idx_reg, 1'b0} +: 2];
    assign need     = need_bytes(code);

    always_comb begin
        state_next     = state_reg;
        hdr_next       = hdr_reg;
        idx_next       = idx_reg;
        bytecnt_next   = bytecnt_reg;
        pad_next       = pad_reg;
        pop_n          = 3'd0;
        out_valid_next = out_valid_reg && !out_ready;
        out_data_next  = out_data_reg;
        out_bm_next    = out_bm_reg;
        blk_done_next  = 1'b0;
        // Nothing advances while the output register is stalled.
        case (state_reg)
            HDR: begin
                if (can_load && fifo_count >= CW'(4)) begin
                    pop_n        = 3'd4;
                    hdr_next     = {b3, b2, b1, b0};
                    idx_next     = 4'd0;
                    bytecnt_next = 2'd0;
                    state_next   = PAY;
                end
            end
            PAY: begin
                if (can_load && fifo_count >= CW'(need)) begin
                    pop_n          = need;
                    out_valid_next = 1'b1;
                    out_bm_next    = code;
                    case (code)
                        CODE_B8:  out_data_next = {24'b0, b0};
                        CODE_B16: out_data_next = {16'b0, b1, b0};
                        CODE_RAW: out_data_next = {b3, b2, b1, b0};
                        default:  out_data_next = 32'b0;
                    endcase
                    bytecnt_next = bytecnt_reg + need[1:0];
                    if (idx_reg == 4'(BLK_WORDS - 1)) begin
                        blk_done_next = 1'b1;
                        idx_next      = 4'd0;
                        pad_next      = 2'd0 - bytecnt_next;
                        state_next    = (pad_next != 2'd0) ? PAD : HDR;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            PAD: begin
                if (can_load && fifo_count >= CW'(pad_reg)) begin
                    pop_n      = {1'b0, pad_reg};
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HDR;
            hdr_reg       <= '0;
            idx_reg       <= '0;
            bytecnt_reg   <= '0;
            pad_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_bm_reg    <= '0;
            blk_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_reg       <= hdr_next;
            idx_reg       <= idx_next;
            bytecnt_reg   <= bytecnt_next;
            pad_reg       <= pad_next;
            // Room for a full word next cycle even if nothing is popped then.
            in_ready_reg  <= (fifo_count_next <= CW'(4));
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_bm_reg    <= out_bm_next;
            blk_done_reg  <= blk_done_next;
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign out_decomp_in = out_data_reg;
    assign out_bitmap    = out_bm_reg;
    assign blk_done      = blk_done_reg;

endmodule

// File: tb/tb_decomp_unpacker.sv
// Scoreboard bench for decomp_unpacker: input words and expected outputs are
// queued per scenario, and each accepted output is checked against the queue head.
module tb_decomp_unpacker;

    localparam int BUF_BYTES = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_decomp_in;
    logic [1:0]  out_bitmap;
    logic        out_valid;
    logic        out_ready;
    logic        blk_done;

    typedef struct packed {
        logic [1:0]  bm;
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] in_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;
    logic        stall_mode = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [31:0] held_d = '0;
    logic [1:0]  held_bm = '0;

    decomp_unpacker #(.BLK_WORDS(16), .BUF_BYTES(BUF_BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_decomp_in (out_decomp_in),
        .out_bitmap    (out_bitmap),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .blk_done      (blk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] bm, input logic [31:0] d, input logic last);
        exp_t e;
        e.bm = bm;
        e.d = d;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) push_exp(2'b00, 32'h0, i == n - 1);
    endtask

    // One cycle: outputs are checked and inputs driven at the falling edge.
    task automatic tick();
        logic first_pres;
        exp_t e;
        @(negedge clk);
        if (!rst_n) return;
        first_pres = !stalled_prev;
        if (out_valid && first_pres) stall_cnt = 0;
        out_ready = 1'b1;
        if (stall_mode && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end
        if (out_valid && !first_pres) begin
            chk("hold_data", out_decomp_in, held_d);
            chk("hold_bitmap", out_bitmap, held_bm);
            chk("done_single", blk_done, 0);
        end
        if (out_valid && first_pres) begin
            if (sb.size() > 0) chk("blk_done", blk_done, sb[0].last);
            held_d = out_decomp_in;
            held_bm = out_bitmap;
        end
        if (!out_valid) chk("done_idle", blk_done, 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                $display("out bitmap=%0d data=%08h blk_done=%0d", out_bitmap, out_decomp_in, blk_done);
                chk("bitmap", out_bitmap, e.bm);
                chk("data", out_decomp_in, e.d);
            end
        end
        stalled_prev = out_valid && !out_ready;
        chk("fifo_cap", dut.fifo_count <= 4'(BUF_BYTES), 1);
        in_valid = in_q.size() > 0;
        in_data = in_valid ? in_q[0] : 32'h0;
        if (in_valid && in_ready) void'(in_q.pop_front());
    endtask

    task automatic run(input string name, input int budget, output int used);
        used = 0;
        while ((sb.size() > 0 || in_q.size() > 0) && used < budget) begin
            tick();
            used++;
        end
        chk({name, "_drain_out"}, sb.size(), 0);
        chk({name, "_drain_in"}, in_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic load_raw_block();
        logic [31:0] w;
        in_q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            in_q.push_back(w);
            push_exp(2'b11, w, i == 15);
        end
    endtask

    task automatic load_mixed_block();
        in_q.push_back(32'h0000_0019);
        in_q.push_back(32'hDDCC_BBAA);
        in_q.push_back(32'h0000_0003);
        in_q.push_back(32'h0102_0304);
        push_exp(2'b01, 32'h0000_00AA, 1'b0);
        push_exp(2'b10, 32'h0000_CCBB, 1'b0);
        push_exp(2'b01, 32'h0000_00DD, 1'b0);
        add_zeros(13);
        push_exp(2'b11, 32'h0102_0304, 1'b0);
        add_zeros(15);
    endtask

    initial begin
        int used;
        int guard;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_decomp_in, 0);
        chk("rst_bitmap", out_bitmap, 0);
        chk("rst_done", blk_done, 0);
        chk("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        #1 chk("ready_pre_clk", in_ready, 0);
        tick();
        chk("ready_post_clk", in_ready, 1);

        load_raw_block();
        run("raw", 200, used);
        chk("raw_thru", used <= 24, 1);

        in_q.push_back(32'h0000_0000);
        add_zeros(16);
        run("zero", 200, used);
        chk("zero_thru", used <= 20, 1);

        load_mixed_block();
        run("mixed", 300, used);

        in_q.push_back(32'h0000_0001);
        in_q.push_back(32'h4433_2211);
        in_q.push_back(32'h0000_0003);
        in_q.push_back(32'hA1B2_C3D4);
        push_exp(2'b01, 32'h0000_0011, 1'b0);
        add_zeros(15);
        push_exp(2'b11, 32'hA1B2_C3D4, 1'b0);
        add_zeros(15);
        run("pad", 300, used);

        stall_mode = 1'b1;
        load_mixed_block();
        run("stall", 1000, used);
        stall_mode = 1'b0;

        load_raw_block();
        guard = 0;
        while (sb.size() > 13 && guard < 100) begin
            tick();
            guard++;
        end
        chk("pre_rst_count", sb.size(), 13);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_decomp_in, 0);
        chk("mid_rst_bitmap", out_bitmap, 0);
        chk("mid_rst_ready", in_ready, 0);
        sb.delete();
        in_q.delete();
        in_valid = 1'b0;
        stalled_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        in_q.push_back(32'h0000_0001);
        in_q.push_back(32'h4433_2211);
        in_q.push_back(32'h0000_0003);
        in_q.push_back(32'hA1B2_C3D4);
        push_exp(2'b01, 32'h0000_0011, 1'b0);
        add_zeros(15);
        push_exp(2'b11, 32'hA1B2_C3D4, 1'b0);
        add_zeros(15);
        run("after_rst", 300, used);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
